// File: rtl/cube_move_sched.sv
// cube_move_sched: sequences the shared cube-move datapath.
// Holds the 120-bit working cube state and a FIFO of face-turn codes. Moves
// go to the external move unit one at a time over a mv_req/mv_ack handshake.
// Optional feature macro: MOVE_MERGE_EN folds a push into the tail entry when
// both turn the same face.
module cube_move_sched #(
  parameter int           DEPTH  = 16,
  parameter logic [119:0] SOLVED = 120'h000BA9876543210000000FAC000688
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     load,
  input  logic [119:0]             init_state,
  input  logic                     push,
  input  logic [4:0]               push_move,
  output logic                     full,
  input  logic                     run,
  output logic                     mv_req,
  output logic [4:0]               mv_code,
  output logic [119:0]             mv_state_o,
  input  logic                     mv_ack,
  input  logic [119:0]             mv_state_i,
  output logic                     busy,
  output logic                     done,
  output logic                     solved,
  output logic [$clog2(DEPTH):0]   step,
  output logic [119:0]             state_out,
  output logic                     err
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [AW-1:0] PTR_ONE   = AW'(1);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);
  localparam logic [CW-1:0] CNT_DEPTH = CW'(DEPTH);
  localparam logic [4:0]    MAX_CODE  = 5'd17;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_FIN   = 2'd2
  } fsm_e;

  fsm_e           fsm_q, fsm_d;
  logic [119:0]   cube_q, cube_d;
  logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [CW-1:0]  step_q, step_d;
  logic           err_q, err_d;

  logic [4:0]     mem_q [DEPTH];
  logic           mem_we;
  logic [AW-1:0]  mem_waddr;
  logic [4:0]     mem_wdata;

  logic           q_full;
  logic           code_ok;
  logic           merge_hit;
  logic           merge_drop;
  logic [4:0]     merge_code;

  assign q_full  = (cnt_q == CNT_DEPTH);
  assign code_ok = (push_move <= MAX_CODE);

`ifdef MOVE_MERGE_EN
  logic [AW-1:0] tail_ptr;
  logic [4:0]    tail_code;
  logic [4:0]    new_face, new_turn, tail_face, tail_turn;
  logic [4:0]    quarter_sum;
  logic [1:0]    quarters;

  assign tail_ptr  = wr_ptr_q - PTR_ONE;
  assign tail_code = mem_q[tail_ptr];

  // Merge decode: compare faces with the live tail and fold the quarter turns.
  always_comb begin
    new_face    = push_move / 5'd3;
    new_turn    = push_move - new_face * 5'd3;
    tail_face   = tail_code / 5'd3;
    tail_turn   = tail_code - tail_face * 5'd3;
    // Each turn code t stands for t+1 clockwise quarters; keep the sum mod 4.
    quarter_sum = new_turn + tail_turn + 5'd2;
    quarters    = quarter_sum[1:0];
    // cnt_q counts only unpopped entries, so a popped tail is never merged.
    merge_hit   = (cnt_q != '0) && code_ok && (new_face == tail_face);
    merge_drop  = (quarters == 2'd0);
    merge_code  = new_face * 5'd3 + {3'b000, quarters} - 5'd1;
  end
`else
  assign merge_hit  = 1'b0;
  assign merge_drop = 1'b0;
  assign merge_code = 5'd0;
`endif

  // Next-state logic for the FSM, queue pointers, cube word, step and error.
  always_comb begin
    // NOTE: every signal gets a default before the case so no latch is inferred.
    fsm_d     = fsm_q;
    cube_d    = cube_q;
    rd_ptr_d  = rd_ptr_q;
    wr_ptr_d  = wr_ptr_q;
    cnt_d     = cnt_q;
    step_d    = step_q;
    err_d     = err_q;
    mem_we    = 1'b0;
    mem_waddr = wr_ptr_q;
    mem_wdata = push_move;

    case (fsm_q)
      S_IDLE: begin
        if (load) begin
          // Load wins over a same-cycle push; the push is silently dropped.
          cube_d   = init_state;
          rd_ptr_d = '0;
          wr_ptr_d = '0;
          cnt_d    = '0;
          err_d    = 1'b0;
        end else if (push) begin
          if (merge_hit) begin
            if (merge_drop) begin
              wr_ptr_d = wr_ptr_q - PTR_ONE;
              cnt_d    = cnt_q - CNT_ONE;
            end else begin
              mem_we    = 1'b1;
              mem_waddr = wr_ptr_q - PTR_ONE;
              mem_wdata = merge_code;
            end
          end else if (code_ok && !q_full) begin
            mem_we   = 1'b1;
            wr_ptr_d = wr_ptr_q + PTR_ONE;
            cnt_d    = cnt_q + CNT_ONE;
          end else begin
            err_d = 1'b1;
          end
        end
        if (run) begin
          step_d = '0;
          fsm_d  = (cnt_d != '0) ? S_ISSUE : S_FIN;
        end
      end

      S_ISSUE: begin
        if (mv_ack) begin
          cube_d   = mv_state_i;
          rd_ptr_d = rd_ptr_q + PTR_ONE;
          cnt_d    = cnt_q - CNT_ONE;
          step_d   = step_q + CNT_ONE;
          if (cnt_q == CNT_ONE) fsm_d = S_FIN;
        end
        if (push) err_d = 1'b1;
      end

      S_FIN: begin
        fsm_d = S_IDLE;
        if (push) err_d = 1'b1;
      end

      default: fsm_d = S_IDLE;
    endcase
  end

  // State registers with asynchronous reset to the solved, empty, idle state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_q    <= S_IDLE;
      cube_q   <= SOLVED;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
      step_q   <= '0;
      err_q    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      fsm_q    <= fsm_d;
      cube_q   <= cube_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      cnt_q    <= cnt_d;
      step_q   <= step_d;
      err_q    <= err_d;
    end
  end

  // Move-code storage; only slots between the pointers are ever read.
  // NOTE: the array has no reset; validity is tracked by cnt_q and the pointers.
  always_ff @(posedge clk) begin
    if (mem_we) mem_q[mem_waddr] <= mem_wdata;
  end

  assign mv_req     = (fsm_q == S_ISSUE);
  assign mv_code    = mv_req ? mem_q[rd_ptr_q] : 5'd0;
  assign mv_state_o = cube_q;
  assign busy       = (fsm_q != S_IDLE);
  assign done       = (fsm_q == S_FIN);
  assign solved     = (cube_q == SOLVED);
  assign step       = step_q;
  assign state_out  = cube_q;
  assign full       = q_full;
  assign err        = err_q;

endmodule

// File: tb/tb_cube_move_sched.sv
// Self-checking bench for cube_move_sched: vector table, hand-written corner
// sequences and randomized runs against a queue-based reference model.
module tb_cube_move_sched;

  localparam int           DEPTH  = 16;
  localparam logic [119:0] SOLVED = 120'h000BA9876543210000000FAC000688;
  localparam int           LIMIT  = 500;

  logic         clk;
  logic         rst_n;
  logic         load;
  logic [119:0] init_state;
  logic         push;
  logic [4:0]   push_move;
  logic         full;
  logic         run;
  logic         mv_req;
  logic [4:0]   mv_code;
  logic [119:0] mv_state_o;
  logic         mv_ack;
  logic [119:0] mv_state_i;
  logic         busy;
  logic         done;
  logic         solved;
  logic [4:0]   step;
  logic [119:0] state_out;
  logic         err;

  cube_move_sched #(.DEPTH(DEPTH), .SOLVED(SOLVED)) dut (
    .clk(clk), .rst_n(rst_n), .load(load), .init_state(init_state),
    .push(push), .push_move(push_move), .full(full), .run(run),
    .mv_req(mv_req), .mv_code(mv_code), .mv_state_o(mv_state_o),
    .mv_ack(mv_ack), .mv_state_i(mv_state_i), .busy(busy), .done(done),
    .solved(solved), .step(step), .state_out(state_out), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: the queue of pending codes, cube word, step count, error.
  int           mq[$];
  logic [119:0] m_state;
  int           m_step;
  bit           m_err;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [119:0] rand120();
    logic [127:0] r;
    r = {$urandom, $urandom, $urandom, $urandom};
    return r[119:0];
  endfunction

  function automatic void m_reset();
    mq.delete();
    m_state = SOLVED;
    m_step  = 0;
    m_err   = 0;
  endfunction

  function automatic void m_push(input int code);
`ifdef MOVE_MERGE_EN
    if (code <= 17 && mq.size() > 0 && (mq[mq.size()-1] / 3) == (code / 3)) begin
      int quarters;
      quarters = ((mq[mq.size()-1] % 3) + 1 + (code % 3) + 1) % 4;
      if (quarters == 0) mq.pop_back();
      else mq[mq.size()-1] = (code / 3) * 3 + quarters - 1;
      return;
    end
`endif
    if (code > 17 || mq.size() == DEPTH) m_err = 1;
    else mq.push_back(code);
  endfunction

  task automatic do_load(input logic [119:0] val);
    load = 1'b1; init_state = val;
    @(posedge clk); #1;
    load = 1'b0;
    m_state = val; mq.delete(); m_err = 0;
    check("load_state", state_out, val);
    check("load_solved", solved, val == SOLVED);
    check("load_err", err, 1'b0);
    check("load_full", full, 1'b0);
  endtask

  task automatic do_push(input int code);
    push = 1'b1; push_move = 5'(code);
    @(posedge clk); #1;
    push = 1'b0;
    m_push(code);
    check("push_err", err, m_err);
    check("push_full", full, mq.size() == DEPTH);
  endtask

  task automatic idle_ack();
    mv_ack = 1'b1; mv_state_i = rand120();
    @(posedge clk); #1;
    mv_ack = 1'b0;
    check("idle_ack_state", state_out, m_state);
    check("idle_ack_busy", busy, 1'b0);
  endtask

  // Run the queue through a move unit waiting min_w..max_w cycles per move.
  // With poke set, load/push/run are thrown at the DUT on the first busy cycle.
  task automatic run_seq(input int min_w, input int max_w, input bit poke);
    int cycles;
    int wait_left;
    logic [119:0] tok;
    run = 1'b1;
    @(posedge clk); #1;
    run = 1'b0;
    m_step = 0;
    if (mq.size() == 0) begin
      check("empty_done", done, 1'b1);
      check("empty_busy", busy, 1'b1);
      check("empty_req", mv_req, 1'b0);
      check("empty_step", step, 0);
    end else begin
      cycles = 0;
      wait_left = $urandom_range(max_w, min_w);
      while (mq.size() > 0) begin
        if (cycles >= LIMIT) begin
          n_tests++; n_fail++;
          $display("FAIL run_timeout: got %0d cycles limit %0d", cycles, LIMIT);
          break;
        end
        check("issue_req", mv_req, 1'b1);
        check("issue_busy", busy, 1'b1);
        check("issue_done", done, 1'b0);
        check("issue_code", mv_code, mq[0]);
        check("issue_state_o", mv_state_o, m_state);
        check("issue_step", step, m_step);
        if (poke && cycles == 0) begin
          push = 1'b1; push_move = 5'($urandom_range(0, 17));
          load = 1'b1; init_state = rand120(); run = 1'b1;
          m_err = 1;
        end
        mv_state_i = rand120();
        if (wait_left == 0) begin
          mv_ack = 1'b1; tok = mv_state_i;
          @(posedge clk); #1;
          mv_ack = 1'b0;
          m_state = tok; mq.pop_front(); m_step++;
          wait_left = $urandom_range(max_w, min_w);
        end else begin
          wait_left--;
          @(posedge clk); #1;
        end
        push = 1'b0; load = 1'b0; run = 1'b0;
        cycles++;
      end
      check("fin_done", done, 1'b1);
      check("fin_req", mv_req, 1'b0);
      check("fin_code", mv_code, 5'd0);
      check("fin_step", step, m_step);
      check("fin_state", state_out, m_state);
      check("fin_solved", solved, m_state == SOLVED);
    end
    @(posedge clk); #1;
    check("end_busy", busy, 1'b0);
    check("end_done", done, 1'b0);
    check("end_err", err, m_err);
    check("end_full", full, 1'b0);
  endtask

  typedef struct {
    bit       ld;
    bit       psh;
    bit       rn;
    int       code;
    bit       exp_full;
    bit       exp_err;
  } vec_t;

  vec_t vecs[22];

  initial begin
    int exp_merge_step;
    logic [119:0] scramble;

    // Vector table: fill to full, overflow, drain, illegal code, load clears.
    vecs[0] = '{ld: 1, psh: 0, rn: 0, code: 0, exp_full: 0, exp_err: 0};
    for (int i = 1; i <= 16; i++)
      vecs[i] = '{ld: 0, psh: 1, rn: 0, code: ((i - 1) % 6) * 3 + ((i - 1) % 3),
                  exp_full: (i == 16), exp_err: 0};
    vecs[17] = '{ld: 0, psh: 1, rn: 0, code: 0,  exp_full: 1, exp_err: 1};
    vecs[18] = '{ld: 0, psh: 0, rn: 1, code: 0,  exp_full: 0, exp_err: 1};
    vecs[19] = '{ld: 1, psh: 0, rn: 0, code: 0,  exp_full: 0, exp_err: 0};
    vecs[20] = '{ld: 0, psh: 1, rn: 0, code: 18, exp_full: 0, exp_err: 1};
    vecs[21] = '{ld: 1, psh: 0, rn: 0, code: 0,  exp_full: 0, exp_err: 0};

    rst_n = 1'b0; load = 1'b0; init_state = '0; push = 1'b0; push_move = '0;
    run = 1'b0; mv_ack = 1'b0; mv_state_i = '0;
    m_reset();

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    check("rst_solved", solved, 1'b1);
    check("rst_busy", busy, 1'b0);
    check("rst_req", mv_req, 1'b0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("idle_solved", solved, 1'b1);
    check("idle_step", step, 0);
    check("idle_busy", busy, 1'b0);
    check("idle_state", state_out, SOLVED);
    check("idle_err", err, 1'b0);
    check("idle_full", full, 1'b0);
    check("idle_done", done, 1'b0);
    check("idle_code", mv_code, 5'd0);

    // Zero-wait run of 0, 4, 17 on a scrambled word.
    scramble = rand120();
    do_load(scramble);
    do_push(0); do_push(4); do_push(17);
    run_seq(0, 0, 0);
    check("three_step", step, 3);

    // Three-cycle wait per move; codes and state must hold while waiting.
    do_push(1); do_push(7); do_push(11); do_push(15); do_push(5);
    run_seq(3, 3, 0);

    // mv_ack with no request outstanding is ignored.
    idle_ack();

    // Vector table.
    for (int v = 0; v < 22; v++) begin
      if (vecs[v].ld) do_load(rand120());
      else if (vecs[v].psh) do_push(vecs[v].code);
      else if (vecs[v].rn) run_seq(0, 2, 0);
      check($sformatf("vec%0d_full", v), full, vecs[v].exp_full);
      check($sformatf("vec%0d_err", v), err, vecs[v].exp_err);
    end

    // Load/push/run while busy are ignored; the push sets err.
    do_push(2); do_push(3);
    run_seq(1, 2, 1);
    check("busy_push_err", err, 1'b1);
    do_load(SOLVED);

    // Reset after the second ack of a five-move run.
    do_push(0); do_push(3); do_push(6); do_push(9); do_push(12);
    run = 1'b1;
    @(posedge clk); #1;
    run = 1'b0;
    check("mid_req", mv_req, 1'b1);
    repeat (2) begin
      mv_ack = 1'b1; mv_state_i = rand120();
      @(posedge clk); #1;
    end
    mv_ack = 1'b0;
    check("mid_step", step, 2);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_req", mv_req, 1'b0);
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_state", state_out, SOLVED);
    check("mid_rst_step", step, 0);
    check("mid_rst_solved", solved, 1'b1);
    check("mid_rst_full", full, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    m_reset();
    run_seq(0, 0, 0);

    // Same-face pushes: merged with MOVE_MERGE_EN, appended without it.
`ifdef MOVE_MERGE_EN
    exp_merge_step = 1;
`else
    exp_merge_step = 2;
`endif
    do_load(rand120());
    do_push(0); do_push(0);
    run_seq(0, 1, 0);
    check("merge_u_u_step", step, exp_merge_step);
`ifdef MOVE_MERGE_EN
    exp_merge_step = 0;
`else
    exp_merge_step = 2;
`endif
    do_push(2); do_push(0);
    run_seq(0, 1, 0);
    check("merge_cancel_step", step, exp_merge_step);

    // Randomized traffic against the reference model.
    for (int it = 0; it < 40; it++) begin
      int n;
      if ($urandom_range(0, 3) == 0) do_load(rand120());
      if ($urandom_range(0, 4) == 0) idle_ack();
      n = $urandom_range(0, 18);
      for (int k = 0; k < n; k++) do_push($urandom_range(0, 19));
      run_seq(0, $urandom_range(0, 3), 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
